regfile_nrmw: RTL and testbench
===============================

REGFILE_NRMW -- requirements
Module: regfile_nrmw

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, meaning the data width in bits.
REQ-002 The block SHALL have parameter NREGS, default 32, meaning the register count; it must be a power of 2 and at least 2.
REQ-003 The block SHALL have parameter NRD, default 2, meaning the number of read ports; the legal range is 1 to 4.
REQ-004 The block SHALL have parameter NWR, default 2, meaning the number of write ports; the legal range is 1 to 2.
REQ-005 The block SHALL define local constant AW = $clog2(NREGS).
REQ-006 The block SHALL have port clk, input, width 1: the single clock; all state updates on the rising edge.
REQ-007 The block SHALL have port rst, input, width 1: asynchronous, active-low reset.
REQ-008 The block SHALL have port rs, input, width NRD*AW: read indices, with port k at bits [k*AW +: AW].
REQ-009 The block SHALL have port dataRs, output, width NRD*XLEN: read data per port.
REQ-010 The block SHALL have port rsBusy, output, width NRD: the scoreboard busy flag for each read index.
REQ-011 The block SHALL have port we, input, width NWR: write enable per write port.
REQ-012 The block SHALL have port rd, input, width NWR*AW: write indices.
REQ-013 The block SHALL have port dataRd, input, width NWR*XLEN: write data.
REQ-014 The block SHALL have port sbSet, input, width 1: marks register sbIdx as pending write.
REQ-015 The block SHALL have port sbIdx, input, width AW: the register to mark busy.

Function
REQ-016 Reads SHALL be combinational: dataRs[k] = regs[rs[k]], with zero latency.
REQ-017 Register 0 SHALL read as 0 at all times, and writes to index 0 SHALL be discarded.
REQ-018 A write SHALL update regs[rd[w]] on the rising clk edge when we[w]=1 and rd[w]!=0.
REQ-019 When two write ports target the same index in the same cycle, the higher port index SHALL win.
REQ-020 The scoreboard SHALL hold one busy bit per register; busy[0] is constant 0.
REQ-021 sbSet=1 SHALL set busy[sbIdx] at the next rising edge.
REQ-022 An enabled write SHALL clear busy[rd[w]] at the same edge as the data write.
REQ-023 When sbSet and a write clear the same index in the same cycle, the set SHALL win, because a new producer supersedes the old one.
REQ-024 sbSet on an index that is already busy SHALL leave it busy, with no error indication.
REQ-025 rsBusy[k] SHALL equal busy[rs[k]] combinationally, and with bypass enabled it SHALL be forced to 0 when rs[k] is being written this cycle.
REQ-026 Read ports SHALL be fully independent; any ports may read the same index.

Reset
REQ-027 When rst=0, all regs and busy bits SHALL clear to 0 asynchronously, so dataRs=0 and rsBusy=0 for all ports while reset is asserted.
REQ-028 A write or sbSet in the cycle that rst falls SHALL be lost.
REQ-029 The first write SHALL take effect at the first rising edge with rst=1.

Configuration
REQ-030 Macro REGFILE_BYPASS_EN SHALL select the read-bypass behaviour.
REQ-031 With REGFILE_BYPASS_EN defined, dataRs[k] SHALL return dataRd[w] when we[w]=1, rd[w]=rs[k] and rs[k]!=0, with the highest matching w winning.
REQ-032 Without REGFILE_BYPASS_EN, reads SHALL return the pre-edge array contents, and the new value SHALL be visible in the cycle after the write.

Structure
REQ-033 Package regfile_pkg SHALL hold XLEN and NREGS defaults, an AW helper function, and typedefs reg_idx_t and reg_data_t.
REQ-034 The scoreboard SHALL be a sub-module, regfile_scoreboard, with ports clk, rst, set, setIdx, clr[NWR], clrIdx[NWR], and a busy vector.
REQ-035 The storage array and read muxes SHALL stay in the top module.

Verification
REQ-036 The bench SHALL check reset: hold rst=0, randomise rs -> all dataRs=0 and rsBusy=0; release, read all indices -> all 0.
REQ-037 The bench SHALL check basic write/read: we[0]=1, rd[0]=5, dataRd[0]=32'hDEADBEEF; next cycle rs[0]=5 -> 32'hDEADBEEF; a write to index 0 with 32'hFFFFFFFF -> rs=0 reads 0.
REQ-038 The bench SHALL check the write conflict: both ports write index 7, port0=32'h1 and port1=32'h2 -> index 7 reads 32'h2.
REQ-039 The bench SHALL check bypass: same cycle we[0]=1, rd[0]=3, dataRd[0]=32'hA5A5A5A5, rs[1]=3 -> with the macro, dataRs[1]=32'hA5A5A5A5 that cycle; without it, the old value that cycle and the new value the next cycle.
REQ-040 The bench SHALL check the scoreboard: sbSet with sbIdx=9 -> rsBusy=1 for rs=9; a write to 9 clears it; sbSet=9 and a write to 9 in the same cycle -> stays busy.
REQ-041 The bench SHALL check reset mid-operation: assert rst asynchronously between edges with busy bits set and registers written -> the outputs clear immediately, without waiting for clk.

Source files
------------

// File: rtl/regfile_pkg.sv
// regfile_pkg
// Shared defaults and types for the multi-port register file.
//   XLEN_DEFAULT  : default data width in bits
//   NREGS_DEFAULT : default register count (power of 2, >= 2)
//   aw()          : index width for a given register count
//   reg_idx_t     : register index at the default size
//   reg_data_t    : register word at the default width
package regfile_pkg;

   localparam int XLEN_DEFAULT  = 32;
   localparam int NREGS_DEFAULT = 32;

   // Index width; a single-entry file still needs one address bit.
   function automatic int aw(input int nregs);
      return (nregs <= 1) ? 1 : $clog2(nregs);
   endfunction

   typedef logic [aw(NREGS_DEFAULT)-1:0] reg_idx_t;
   typedef logic [XLEN_DEFAULT-1:0]      reg_data_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard
// One pending-write bit per register. A set marks a register as awaiting a
// producer; an enabled write clears it. Register 0 is never busy.
// Ports:
//   clk     : clock, rising edge
//   rst     : asynchronous active-low reset, clears all busy bits
//   set     : mark setIdx busy at the next edge
//   setIdx  : register to mark busy
//   clr     : per write port, clear clrIdx[w] at the next edge
//   clrIdx  : per write port register index, port w at [w*AW +: AW]
//   busy    : busy vector, bit i for register i (bit 0 always 0)
module regfile_scoreboard
   import regfile_pkg::*;
#(
   parameter int NREGS = NREGS_DEFAULT,
   parameter int NWR   = 2,
   localparam int AW   = $clog2(NREGS)
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              set,
   input  logic [AW-1:0]     setIdx,
   input  logic [NWR-1:0]    clr,
   input  logic [NWR*AW-1:0] clrIdx,
   output logic [NREGS-1:0]  busy
);

   // Storage only for registers 1..NREGS-1; register 0 is hardwired idle.
   logic [NREGS-1:1] busy_q;
   logic [NREGS-1:1] busy_d;

   // Clears are applied first so a same-cycle set overrides them: the new
   // producer supersedes the one that is just retiring.
   always_comb begin
      busy_d = busy_q;
      for (int w = 0; w < NWR; w++) begin
         if (clr[w] && clrIdx[w*AW +: AW] != '0)
            busy_d[clrIdx[w*AW +: AW]] = 1'b0;
      end
      if (set && setIdx != '0)
         busy_d[setIdx] = 1'b1;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) busy_q <= '0;
      else      busy_q <= busy_d;
   end

   assign busy = {busy_q, 1'b0};

endmodule

// File: rtl/regfile_nrmw.sv
// regfile_nrmw
// Multi-read, multi-write register file with a pending-write scoreboard.
// Register 0 reads as zero and ignores writes. Reads are combinational.
// Optional macro REGFILE_BYPASS_EN: reads of a register being written this
// cycle return the incoming data (highest write port wins) and report idle.
// Ports:
//   clk    : clock, rising edge
//   rst    : asynchronous active-low reset, clears registers and busy bits
//   rs     : read indices, port k at [k*AW +: AW]
//   dataRs : read data, port k at [k*XLEN +: XLEN]
//   rsBusy : scoreboard busy flag of each read index
//   we     : write enable per write port
//   rd     : write indices, port w at [w*AW +: AW]
//   dataRd : write data, port w at [w*XLEN +: XLEN]
//   sbSet  : mark sbIdx as pending write
//   sbIdx  : register to mark busy
module regfile_nrmw
   import regfile_pkg::*;
#(
   parameter int XLEN  = XLEN_DEFAULT,
   parameter int NREGS = NREGS_DEFAULT,
   parameter int NRD   = 2,
   parameter int NWR   = 2,
   localparam int AW   = $clog2(NREGS)
)(
   input  logic                clk,
   input  logic                rst,
   input  logic [NRD*AW-1:0]   rs,
   output logic [NRD*XLEN-1:0] dataRs,
   output logic [NRD-1:0]      rsBusy,
   input  logic [NWR-1:0]      we,
   input  logic [NWR*AW-1:0]   rd,
   input  logic [NWR*XLEN-1:0] dataRd,
   input  logic                sbSet,
   input  logic [AW-1:0]       sbIdx
);

   logic [XLEN-1:0]  regs [NREGS];
   logic [NREGS-1:0] busy;

   // Later write ports are evaluated last, so the higher port index wins
   // when two ports target the same register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      end else begin
         for (int w = 0; w < NWR; w++) begin
            if (we[w] && rd[w*AW +: AW] != '0)
               regs[rd[w*AW +: AW]] <= dataRd[w*XLEN +: XLEN];
         end
      end
   end

   regfile_scoreboard #(
      .NREGS (NREGS),
      .NWR   (NWR)
   ) u_sb (
      .clk    (clk),
      .rst    (rst),
      .set    (sbSet),
      .setIdx (sbIdx),
      .clr    (we),
      .clrIdx (rd),
      .busy   (busy)
   );

   for (genvar k = 0; k < NRD; k++) begin : g_rd
      logic [AW-1:0]   idx;
      logic [XLEN-1:0] data;
      logic            bsy;

      assign idx = rs[k*AW +: AW];

      always_comb begin
         data = (idx == '0) ? '0 : regs[idx];
         bsy  = busy[idx];
`ifdef REGFILE_BYPASS_EN
         // Forwarded data is already on its way in, so the read is not stale.
         for (int w = 0; w < NWR; w++) begin
            if (we[w] && rd[w*AW +: AW] == idx && idx != '0) begin
               data = dataRd[w*XLEN +: XLEN];
               bsy  = 1'b0;
            end
         end
`endif
      end

      assign dataRs[k*XLEN +: XLEN] = data;
      assign rsBusy[k]              = bsy;
   end

endmodule

// File: tb/tb_regfile_nrmw.sv
// tb_regfile_nrmw
// Directed bench for regfile_nrmw at default parameters (XLEN=32, NREGS=32,
// NRD=2, NWR=2). Expectations follow the REGFILE_BYPASS_EN setting of the
// build. Ends with one TB_RESULT summary line.
module tb_regfile_nrmw;

   localparam int XLEN = 32;
   localparam int AW   = 5;
`ifdef REGFILE_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst;
   logic [9:0]    rs;
   logic [63:0]   dataRs;
   logic [1:0]    rsBusy;
   logic [1:0]    we;
   logic [9:0]    rd;
   logic [63:0]   dataRd;
   logic          sbSet;
   logic [4:0]    sbIdx;

   int checks   = 0;
   int failures = 0;

   regfile_nrmw dut (
      .clk    (clk),
      .rst    (rst),
      .rs     (rs),
      .dataRs (dataRs),
      .rsBusy (rsBusy),
      .we     (we),
      .rd     (rd),
      .dataRd (dataRd),
      .sbSet  (sbSet),
      .sbIdx  (sbIdx)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Advance one rising edge and land mid-cycle, away from the edge.
   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic set_rs(input int a, input int b);
      rs = {5'(b), 5'(a)};
      #1;
   endtask

   task automatic wr(input logic [1:0] en, input int i0, input logic [31:0] d0,
                     input int i1, input logic [31:0] d1);
      we     = en;
      rd     = {5'(i1), 5'(i0)};
      dataRd = {d1, d0};
   endtask

   task automatic idle();
      we = '0; rd = '0; dataRd = '0; sbSet = 1'b0; sbIdx = '0;
   endtask

   initial begin
      rst = 1'b0;
      rs  = '0;
      idle();

      // Reset held: outputs zero whatever is read, pending writes ignored.
      wr(2'b01, 4, 32'h1234_5678, 0, 32'h0);
      sbSet = 1'b1; sbIdx = 5'd4;
      step();
      for (int i = 0; i < 4; i++) begin
         set_rs(int'($urandom_range(0, 31)), int'($urandom_range(0, 31)));
         chk("rst_data", dataRs, 64'h0);
         chk("rst_busy", {62'h0, rsBusy}, 64'h0);
      end
      idle();
      #3 rst = 1'b1;
      step();

      // After release every index reads zero and idle.
      for (int i = 0; i < 32; i += 2) begin
         set_rs(i, i + 1);
         chk("post_rst_data", dataRs, 64'h0);
         chk("post_rst_busy", {62'h0, rsBusy}, 64'h0);
      end

      // Basic write then read back.
      wr(2'b01, 5, 32'hDEAD_BEEF, 0, 32'h0);
      step();
      idle();
      set_rs(5, 0);
      chk("wr5", dataRs, {32'h0, 32'hDEAD_BEEF});

      // Writes to register 0 are discarded.
      wr(2'b01, 0, 32'hFFFF_FFFF, 0, 32'h0);
      step();
      idle();
      set_rs(0, 0);
      chk("r0_zero", dataRs, 64'h0);

      // Same-index write conflict: port 1 wins.
      wr(2'b11, 7, 32'h1, 7, 32'h2);
      step();
      idle();
      set_rs(7, 5);
      chk("conflict7", dataRs, {32'hDEAD_BEEF, 32'h2});

      // Read of the register being written in the same cycle.
      wr(2'b01, 3, 32'hA5A5_A5A5, 0, 32'h0);
      set_rs(0, 3);
      chk("byp_same", dataRs[63:32], BYP ? 64'hA5A5_A5A5 : 64'h0);
      step();
      idle();
      #1;
      chk("byp_next", dataRs[63:32], 64'hA5A5_A5A5);

      // Scoreboard set.
      sbSet = 1'b1; sbIdx = 5'd9;
      step();
      idle();
      set_rs(9, 8);
      chk("sb_set9", {62'h0, rsBusy}, 64'h1);

      // Setting an already busy register keeps it busy.
      sbSet = 1'b1; sbIdx = 5'd9;
      step();
      idle();
      #1;
      chk("sb_reset9", {62'h0, rsBusy}, 64'h1);

      // Write to 9 clears it; during the write cycle bypass reports idle.
      wr(2'b01, 9, 32'h99, 0, 32'h0);
      #1;
      chk("sb_wr_cycle", {62'h0, rsBusy}, BYP ? 64'h0 : 64'h1);
      step();
      idle();
      #1;
      chk("sb_clr9", {62'h0, rsBusy}, 64'h0);
      chk("rd9", dataRs[31:0], 64'h99);

      // Set and clear of the same index in one cycle: set wins.
      sbSet = 1'b1; sbIdx = 5'd9;
      wr(2'b10, 0, 32'h0, 9, 32'h77);
      step();
      idle();
      #1;
      chk("sb_set_wins", {62'h0, rsBusy}, 64'h1);
      chk("rd9_new", dataRs[31:0], 64'h77);

      // Asynchronous reset mid-cycle with live state.
      set_rs(5, 9);
      chk("pre_async_data", dataRs[31:0], 64'hDEAD_BEEF);
      chk("pre_async_busy", {62'h0, rsBusy}, 64'h2);
      wr(2'b01, 12, 32'hCAFE_0000, 0, 32'h0);
      rst = 1'b0;
      #1;
      chk("async_data", dataRs, 64'h0);
      chk("async_busy", {62'h0, rsBusy}, 64'h0);
      step();
      // First write after release lands at the first edge with rst high.
      wr(2'b01, 4, 32'h0BAD_F00D, 0, 32'h0);
      rst = 1'b1;
      step();
      idle();
      set_rs(12, 4);
      chk("lost_wr12", dataRs[31:0], 64'h0);
      chk("first_wr4", dataRs[63:32], 64'h0BAD_F00D);
      set_rs(7, 9);
      chk("cleared7", dataRs[31:0], 64'h0);
      chk("cleared9busy", {62'h0, rsBusy}, 64'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Overall time bound so the run always terminates.
   initial begin
      #100000;
      $display("FAIL timeout got=running exp=finished");
      $fatal(1);
   end

endmodule
